// File: rtl/arp_pkt_gen_pkg.sv
// Shared constants, body length selection and FSM state type for the ARP frame generator.
// Optional build macro ARP_PAD_EN pads the body to the minimum Ethernet payload.
package arp_pkg;

    localparam logic [15:0] ETH_TYPE_ARP    = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IPV4   = 16'h0800;
    localparam logic [15:0] ARP_HTYPE_ETH   = 16'h0001;
    localparam logic [7:0]  ARP_HLEN        = 8'd6;
    localparam logic [7:0]  ARP_PLEN        = 8'd4;
    localparam logic [15:0] ARP_OP_REQ      = 16'd1;
    localparam logic [15:0] ARP_OP_REP      = 16'd2;
    localparam int          ARP_BODY_LEN    = 28;
    localparam int          ETH_MIN_PAYLOAD = 46;
    localparam logic [47:0] MAC_BCAST       = 48'hFFFF_FFFF_FFFF;

`ifdef ARP_PAD_EN
    localparam int ARP_LEN = ETH_MIN_PAYLOAD;
`else
    localparam int ARP_LEN = ARP_BODY_LEN;
`endif

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        KICK,
        WAIT_TX
    } arp_state_t;

endpackage

// File: rtl/arp_pkt_gen_if.sv
// FIFO write port and framer control bundle between the ARP generator and the TX framer/FIFO pair.
interface arp_pkt_gen_if;

    logic        fifo_wrreq;
    logic [7:0]  fifo_wrdata;
    logic        fifo_full;
    logic        frame_tx_en;
    logic [15:0] frame_len;
    logic [15:0] frame_type;
    logic [47:0] target_mac_addr;
    logic        frame_done;

    modport master (
        output fifo_wrreq,
        output fifo_wrdata,
        output frame_tx_en,
        output frame_len,
        output frame_type,
        output target_mac_addr,
        input  fifo_full,
        input  frame_done
    );

    modport slave (
        input  fifo_wrreq,
        input  fifo_wrdata,
        input  frame_tx_en,
        input  frame_len,
        input  frame_type,
        input  target_mac_addr,
        output fifo_full,
        output frame_done
    );

endinterface

// File: rtl/arp_pkt_gen_byte_sel.sv
// Stateless byte selector: maps a body byte index plus latched request fields to the ARP body byte.
module arp_byte_sel
    import arp_pkg::*;
#(
    parameter logic [47:0] SRC_MAC = 48'h000A3501FEC0,
    parameter logic [31:0] SRC_IP  = 32'hC0A80002
) (
    input  logic [5:0]  byte_cnt,
    input  logic        op_reply,
    input  logic [47:0] dst_mac,
    input  logic [31:0] dst_ip,
    output logic [7:0]  body_byte
);

    logic [ARP_BODY_LEN*8-1:0] body_vec;
    logic [7:0]                body_tbl [64];

    assign body_vec = {ARP_HTYPE_ETH, ETH_TYPE_IPV4, ARP_HLEN, ARP_PLEN,
                       op_reply ? ARP_OP_REP : ARP_OP_REQ,
                       SRC_MAC, SRC_IP,
                       op_reply ? dst_mac : 48'h0,
                       dst_ip};

    // Every 6-bit index resolves to a byte; indices past the body are zero padding.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_tbl
            if (gi < ARP_BODY_LEN) begin : g_body
                assign body_tbl[gi] = body_vec[(ARP_BODY_LEN-1-gi)*8 +: 8];
            end else begin : g_pad
                assign body_tbl[gi] = 8'h00;
            end
        end
    endgenerate

    assign body_byte = body_tbl[byte_cnt];

endmodule

// File: rtl/arp_pkt_gen.sv
// ARP request/reply generator: streams the body into the TX FIFO, kicks the framer, waits for completion.
// Build with ARP_PAD_EN defined to pad the body to 46 bytes.
module arp_pkt_gen
    import arp_pkg::*;
#(
    parameter logic [47:0] SRC_MAC    = 48'h000A3501FEC0,
    parameter logic [31:0] SRC_IP     = 32'hC0A80002,
    parameter int          TX_TIMEOUT = 4096
) (
    input  logic          gmii_tx_clk,
    input  logic          rst,
    input  logic          send_req,
    input  logic          op_reply,
    input  logic [47:0]   dst_mac,
    input  logic [31:0]   dst_ip,
    output logic          busy,
    output logic          done,
    output logic          timeout_err,
    arp_pkt_gen_if.master tx
);

    localparam int               WD_W      = $clog2(TX_TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TX_TIMEOUT - 1);
    localparam logic [5:0]       LAST_BYTE = 6'(ARP_LEN - 1);

    arp_state_t      state_reg;
    logic [5:0]      byte_cnt_reg;
    logic [WD_W-1:0] watchdog_reg;
    logic            op_reply_reg;
    logic [47:0]     dst_mac_reg;
    logic [31:0]     dst_ip_reg;
    logic [47:0]     target_mac_reg;
    logic            done_reg;
    logic            timeout_reg;
    logic [7:0]      sel_byte;

    arp_byte_sel #(
        .SRC_MAC (SRC_MAC),
        .SRC_IP  (SRC_IP)
    ) u_byte_sel (
        .byte_cnt  (byte_cnt_reg),
        .op_reply  (op_reply_reg),
        .dst_mac   (dst_mac_reg),
        .dst_ip    (dst_ip_reg),
        .body_byte (sel_byte)
    );

    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            byte_cnt_reg   <= '0;
            watchdog_reg   <= '0;
            op_reply_reg   <= 1'b0;
            dst_mac_reg    <= '0;
            dst_ip_reg     <= '0;
            target_mac_reg <= '0;
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (send_req) begin
                        op_reply_reg <= op_reply;
                        dst_mac_reg  <= dst_mac;
                        dst_ip_reg   <= dst_ip;
                        byte_cnt_reg <= '0;
                        state_reg    <= WRITE;
                    end
                end
                WRITE: begin
                    if (!tx.fifo_full) begin
                        // Counter parks on the last index instead of wrapping.
                        if (byte_cnt_reg == LAST_BYTE) begin
                            target_mac_reg <= op_reply_reg ? dst_mac_reg : MAC_BCAST;
                            state_reg      <= KICK;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + 6'd1;
                        end
                    end
                end
                KICK: begin
                    watchdog_reg <= '0;
                    state_reg    <= WAIT_TX;
                end
                WAIT_TX: begin
                    // Completion takes priority over a simultaneous watchdog expiry.
                    if (tx.frame_done) begin
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end else if (watchdog_reg == WD_LAST) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        watchdog_reg <= watchdog_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy                = (state_reg != IDLE);
    assign done                = done_reg;
    assign timeout_err         = timeout_reg;
    assign tx.fifo_wrreq       = (state_reg == WRITE) && !tx.fifo_full;
    assign tx.fifo_wrdata      = (state_reg == WRITE) ? sel_byte : 8'h00;
    assign tx.frame_tx_en      = (state_reg == KICK);
    assign tx.frame_len        = 16'(ARP_LEN);
    assign tx.frame_type       = ETH_TYPE_ARP;
    assign tx.target_mac_addr  = target_mac_reg;

endmodule

// File: tb/tb_arp_pkt_gen.sv
// Self-checking bench for arp_pkt_gen: table of frame scenarios plus random rows against a byte-list model.
module tb_arp_pkt_gen;

    localparam int          TO       = 64;
    localparam logic [47:0] T_SRC_MAC = 48'h000A3501FEC0;
    localparam logic [31:0] T_SRC_IP  = 32'hC0A80002;
`ifdef ARP_PAD_EN
    localparam int EXP_LEN = 46;
`else
    localparam int EXP_LEN = 28;
`endif

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic        op;
        logic [47:0] mac;
        logic [31:0] ip;
        int          full_at;
        int          full_len;
        int          done_after;   // negative: frame_done never arrives
        logic [47:0] exp_target;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        send_req;
    logic        op_reply;
    logic [47:0] dst_mac;
    logic [31:0] dst_ip;
    logic        busy;
    logic        done;
    logic        timeout_err;

    arp_pkt_gen_if tx();

    arp_pkt_gen #(.TX_TIMEOUT(TO)) dut (
        .gmii_tx_clk (clk),
        .rst         (rst),
        .send_req    (send_req),
        .op_reply    (op_reply),
        .dst_mac     (dst_mac),
        .dst_ip      (dst_ip),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .tx          (tx)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    logic [7:0]  wr_q[$];
    int          wr_cyc[$];
    int          kick_q[$];
    int          done_q[$];
    int          to_q[$];
    logic [47:0] target_at_kick;
    logic [15:0] len_at_kick;
    logic        busy_at_done;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx.fifo_wrreq) begin
            wr_q.push_back(tx.fifo_wrdata);
            wr_cyc.push_back(cyc);
        end
        if (tx.frame_tx_en) begin
            kick_q.push_back(cyc);
            target_at_kick <= tx.target_mac_addr;
            len_at_kick    <= tx.frame_len;
        end
        if (done) begin
            done_q.push_back(cyc);
            busy_at_done <= busy;
        end
        if (timeout_err) to_q.push_back(cyc);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference body: fields appended byte by byte, most significant byte first.
    function automatic bq_t model(input logic op, input logic [47:0] mac, input logic [31:0] ip);
        bq_t q;
        logic [47:0] tha;
        q = {8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, (op ? 8'h02 : 8'h01)};
        for (int i = 5; i >= 0; i--) q.push_back(8'(T_SRC_MAC >> (8 * i)));
        for (int i = 3; i >= 0; i--) q.push_back(8'(T_SRC_IP >> (8 * i)));
        tha = op ? mac : 48'h0;
        for (int i = 5; i >= 0; i--) q.push_back(8'(tha >> (8 * i)));
        for (int i = 3; i >= 0; i--) q.push_back(8'(ip >> (8 * i)));
        while (q.size() < EXP_LEN) q.push_back(8'h00);
        return q;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    64'(busy), 64'd0);
        check({tag, "_wrreq"},   64'(tx.fifo_wrreq), 64'd0);
        check({tag, "_wrdata"},  64'(tx.fifo_wrdata), 64'd0);
        check({tag, "_tx_en"},   64'(tx.frame_tx_en), 64'd0);
        check({tag, "_target"},  64'(tx.target_mac_addr), 64'd0);
        check({tag, "_done"},    64'(done), 64'd0);
        check({tag, "_timeout"}, 64'(timeout_err), 64'd0);
        check({tag, "_type"},    64'(tx.frame_type), 64'h0806);
        check({tag, "_len"},     64'(tx.frame_len), 64'(EXP_LEN));
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int  budget;
        int  k;
        int  rel_cyc;
        int  mism;
        bit  stalled;
        bq_t exp_q;

        wr_q.delete(); wr_cyc.delete(); kick_q.delete(); done_q.delete(); to_q.delete();
        exp_q = model(v.op, v.mac, v.ip);

        op_reply = v.op; dst_mac = v.mac; dst_ip = v.ip; send_req = 1'b1;
        step(1);
        send_req = 1'b0;
        op_reply = ~v.op; dst_mac = ~v.mac; dst_ip = ~v.ip;

        stalled = 1'b0; rel_cyc = -1; budget = 0;
        while (kick_q.size() == 0 && budget < 400) begin
            if (!stalled && v.full_len > 0 && wr_q.size() == v.full_at) begin
                tx.fifo_full = 1'b1;
                step(v.full_len);
                tx.fifo_full = 1'b0;
                rel_cyc = cyc;
                stalled = 1'b1;
            end else begin
                step(1);
            end
            budget++;
        end
        check({tag, "_kick_seen"}, 64'(kick_q.size() > 0), 64'd1);
        if (kick_q.size() == 0) begin
            rst = 1'b1; step(1); rst = 1'b0; step(1);
            return;
        end
        k = kick_q[0];

        check({tag, "_nbytes"}, 64'(wr_q.size()), 64'(EXP_LEN));
        mism = 0;
        for (int i = 0; i < EXP_LEN && i < wr_q.size(); i++)
            if (wr_q[i] !== exp_q[i]) mism++;
        check({tag, "_body_mismatches"}, 64'(mism), 64'd0);
        check({tag, "_kick_after_last"}, 64'(k), 64'(wr_cyc[wr_cyc.size()-1] + 1));
        check({tag, "_target"}, 64'(target_at_kick), 64'(v.exp_target));
        check({tag, "_frame_len"}, 64'(len_at_kick), 64'(EXP_LEN));
        if (stalled) check({tag, "_stall_release"}, 64'(wr_cyc[v.full_at]), 64'(rel_cyc));

        if (v.done_after >= 0) begin
            while (cyc < k + v.done_after) begin
                send_req = (cyc == k + 2);
                step(1);
            end
            send_req = 1'b1; tx.frame_done = 1'b1;
            step(1);
            send_req = 1'b0; tx.frame_done = 1'b0;
            budget = 0;
            while (done_q.size() == 0 && budget < 5) begin step(1); budget++; end
            check({tag, "_done_cycle"}, 64'(done_q.size() ? done_q[0] : -1), 64'(k + v.done_after + 1));
            check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
        end else begin
            budget = 0;
            while (to_q.size() == 0 && done_q.size() == 0 && budget < TO + 20) begin
                send_req = (cyc == k + 2);
                step(1);
                budget++;
            end
            send_req = 1'b0;
            check({tag, "_timeout_cycle"}, 64'(to_q.size() ? to_q[0] : -1), 64'(k + TO + 1));
        end

        step(20);
        check({tag, "_single_kick"}, 64'(kick_q.size()), 64'd1);
        check({tag, "_single_end_pulse"}, 64'(done_q.size() + to_q.size()), 64'd1);
        check({tag, "_idle_after"}, 64'(busy), 64'd0);
    endtask

    vec_t vecs[$];
    vec_t v;
    int   budget;

    initial begin
        rst = 1'b1; send_req = 1'b0; op_reply = 1'b0; dst_mac = '0; dst_ip = '0;
        tx.fifo_full = 1'b0; tx.frame_done = 1'b0;
        step(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        step(2);

        vecs.push_back('{1'b0, 48'hDEADBEEF0001, 32'hC0A80003, 0, 0, 5, 48'hFFFFFFFFFFFF});
        vecs.push_back('{1'b1, 48'h112233445566, 32'hC0A80003, 0, 0, 5, 48'h112233445566});
        vecs.push_back('{1'b0, 48'h0, 32'hC0A80003, 10, 5, 5, 48'hFFFFFFFFFFFF});
        vecs.push_back('{1'b1, 48'hA1B2C3D4E5F6, 32'h0A000001, 0, 0, 20, 48'hA1B2C3D4E5F6});
        vecs.push_back('{1'b0, 48'h0, 32'hC0A80009, 0, 0, -1, 48'hFFFFFFFFFFFF});
        vecs.push_back('{1'b1, 48'h665544332211, 32'hC0A800FE, EXP_LEN-1, 3, 2, 48'h665544332211});
        for (int i = 0; i < 6; i++) begin
            v.op         = 1'($urandom);
            v.mac        = {16'($urandom), 32'($urandom)};
            v.ip         = $urandom;
            v.full_at    = $urandom_range(0, EXP_LEN - 1);
            v.full_len   = $urandom_range(0, 4);
            v.done_after = $urandom_range(2, 30);
            v.exp_target = v.op ? v.mac : 48'hFFFFFFFFFFFF;
            vecs.push_back(v);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
            $display("[TB] vector %0d op=%0d ip=%h stall@%0d/%0d done_after=%0d", i, vecs[i].op,
                     vecs[i].ip, vecs[i].full_at, vecs[i].full_len, vecs[i].done_after);
        end

        // Reset in the middle of the body, then a fresh frame must restart at byte 0.
        wr_q.delete(); wr_cyc.delete();
        op_reply = 1'b1; dst_mac = 48'h0102030405FF; dst_ip = 32'h01020304; send_req = 1'b1;
        step(1);
        send_req = 1'b0;
        budget = 0;
        while (wr_q.size() < 15 && budget < 100) begin step(1); budget++; end
        check("midrst_reached_byte15", 64'(wr_q.size()), 64'd15);
        rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        step(2);
        rst = 1'b0;
        step(1);
        run_frame('{1'b0, 48'h0, 32'hC0A80003, 0, 0, 3, 48'hFFFFFFFFFFFF}, "after_rst");
        $display("[TB] mid-body reset sequence complete");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

endmodule
